// File: rtl/gpio_ctrl_pkg.sv
// Shared types and defaults for the GPIO rotator trigger control blocks.
// The trigger arbiter and any software model of the rotator use these constants.
package gpio_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_OUT_WIDTH    = 5;

    // Rotator output straight after reset: the single hot bit sits in the MSB.
    localparam logic [DEF_OUT_WIDTH-1:0] POSITION_INIT = 5'b10000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       base;
    logic [IDX_W:0]       offset;
    logic [IDX_W:0]       sum;

    // Rotate the request vector so the first candidate lands at bit 0, take
    // the lowest set bit, then map the offset back to an absolute index.
    always_comb begin
        base = {1'b0, last_i} + (IDX_W+1)'(1);
        if (base >= (IDX_W+1)'(NUM_REQ)) begin
            base = '0;
        end
        doubled = {req_i, req_i};
        rotated = NUM_REQ'(doubled >> base);
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (IDX_W+1)'(i);
            end
        end
        sum = base + offset;
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        idx_o  = sum[IDX_W-1:0];
        pick_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/gpio_trigger_arbiter.sv
// Shares the GPIO rotator trigger among several requesters: one clean
// high pulse plus low gap per grant, with a shadow of the rotator output.
module gpio_trigger_arbiter
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 trigger_o,
    output logic                 busy_o,
    output logic [OUT_WIDTH-1:0] position_o,
    output logic [15:0]          trigger_count_o
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0]     PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [OUT_WIDTH-1:0] POS_RESET  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]     LAST_RESET = IDX_W'(NUM_REQ - 1);

    state_t               state_q,    state_d;
    logic [TMR_W-1:0]     timer_q,    timer_d;
    logic [IDX_W-1:0]     last_q,     last_d;
    logic [NUM_REQ-1:0]   grant_q,    grant_d;
    logic [NUM_REQ-1:0]   done_q,     done_d;
    logic                 trigger_q,  trigger_d;
    logic                 busy_q,     busy_d;
    logic [OUT_WIDTH-1:0] position_q, position_d;
    logic [15:0]          trig_count_q, trig_count_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i  (req_i),
        .last_i (last_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    // last_q doubles as the winner of the sequence in flight, so done can
    // be steered back to the same requester when the gap expires.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_d       = last_q;
        grant_d      = '0;
        done_d       = '0;
        trigger_d    = trigger_q;
        busy_d       = busy_q;
        position_d   = position_q;
        trig_count_d = trig_count_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && (|pick)) begin
                    state_d      = ST_PULSE;
                    timer_d      = PULSE_LOAD;
                    last_d       = pick_idx;
                    grant_d      = pick;
                    trigger_d    = 1'b1;
                    busy_d       = 1'b1;
                    trig_count_d = trig_count_q + 16'd1;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    state_d    = ST_GAP;
                    timer_d    = GAP_LOAD;
                    trigger_d  = 1'b0;
                    position_d = {position_q[OUT_WIDTH-2:0], position_q[OUT_WIDTH-1]};
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = NUM_REQ'(1) << last_q;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                trigger_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            last_q       <= LAST_RESET;
            grant_q      <= '0;
            done_q       <= '0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            position_q   <= POS_RESET;
            trig_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            position_q   <= position_d;
            trig_count_q <= trig_count_d;
        end
    end

    assign grant_o         = grant_q;
    assign done_o          = done_q;
    assign trigger_o       = trigger_q;
    assign busy_o          = busy_q;
    assign position_o      = position_q;
    assign trigger_count_o = trig_count_q;

endmodule

// File: doc/gpio_trigger_arbiter.md
# gpio_trigger_arbiter

Round-robin scheduler that shares the single `trigger` input of the GPIO rotator (`out` one-hot, resets to `5'b10000`, rotates left once per trigger rising edge) among several requesters. Each granted request produces exactly one well-formed trigger pulse followed by a low gap, so the rotator's edge-handling logic sees a clean high then low. The block keeps a shadow copy of the rotator's expected output and a trigger count for software and verification checks.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OUT_WIDTH`, 5: width of the rotator output being shadowed.
- `PULSE_CYCLES`, 2: cycles `trigger` is held high per grant, ≥1.
- `GAP_CYCLES`, 2: cycles `trigger` is held low after each pulse, ≥1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new grants; an in-progress pulse/gap completes.
- `req`  in  NUM_REQ  level requests; requester holds until its `grant`, then drops.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse on acceptance.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse when that requester's pulse and gap have finished.
- `trigger`  out  1  registered drive to the rotator.
- `busy`  out  1  high in PULSE or GAP.
- `position`  out  OUT_WIDTH  expected rotator output.
- `trigger_count`  out  16  number of grants issued, wrapping.

## Operation
- FSM states: IDLE, PULSE, GAP.
- IDLE: if `enable` and `|req`, pick winner via round-robin, go to PULSE, load pulse counter, latch winner index.
- PULSE: `trigger`=1 for PULSE_CYCLES cycles, then go to GAP. On entry to GAP, `position` rotates left: {position[W-2:0], position[W-1]}.
- GAP: `trigger`=0 for GAP_CYCLES cycles, then return to IDLE and assert `done[winner]` for one cycle.
- Round-robin: search starts at last winner + 1 and wraps modulo NUM_REQ. After reset, last winner = NUM_REQ-1, so req[0] has highest priority first.
- `trigger_count` increments at each grant and wraps 0xFFFF→0x0000.
- A `req` that drops before it is granted is ignored; no grant is issued for it.
- `enable` deasserted mid-PULSE or mid-GAP does not truncate the sequence.
- Reset values: `trigger`=0, `grant`=0, `done`=0, `busy`=0, state=IDLE, `position`=1<<(OUT_WIDTH-1) (5'b10000), `trigger_count`=0. Reset asserted mid-sequence aborts immediately, with no `done` pulse.

## Timing
- All outputs are registered.
- Edge E samples `req` in IDLE. From E: `grant` is high for one cycle, `trigger`=1, `busy`=1.
- `trigger` is high for exactly PULSE_CYCLES cycles, then low for GAP_CYCLES cycles.
- `position` updates on the same edge that `trigger` falls.
- `done` rises on the edge the FSM enters IDLE (E + PULSE_CYCLES + GAP_CYCLES) and lasts one cycle. `busy` falls on that same edge.
- Arbitration is allowed in the cycle `done` is high, so the next grant comes at the following edge. Minimum grant-to-grant period is PULSE_CYCLES+GAP_CYCLES+1 cycles.
- Simultaneous requests: exactly one grant per sequence. Losers stay pending and are served in round-robin order.

## Structure
- Shared package `gpio_ctrl_pkg` holds:
  - state typedef (IDLE/PULSE/GAP);
  - defaults: PULSE_CYCLES, GAP_CYCLES, OUT_WIDTH;
  - reset constant POSITION_INIT.
- Sub-module `rr_arbiter`: combinational round-robin pick, parameter NUM_REQ. Inputs: req vector and last-winner index. Outputs: one-hot pick and index.
- Top level holds the FSM, counters, the `position` shadow and `trigger_count`.

## Test plan
- Reset, then req=4'b0001 → grant[0] pulse; trigger high 2 cycles, then low 2 cycles; done[0] at E+4; position 5'b10000→5'b00001; trigger_count=1.
- req=4'b1111 held and dropped per grant → grants in order 0,1,2,3. Wrapped against a real rotator instance, its out equals `position` after each done (00001, 00010, 00100, 01000).
- After last winner=2, req=4'b1001 → grant[3] before grant[0].
- enable=0 with req pending → no grant. enable dropped mid-PULSE → sequence completes, done pulses, no new grant.
- reset asserted mid-PULSE → trigger=0 immediately, no done, position=5'b10000. First grant after reset goes to req[0].
- Preload trigger_count to 0xFFFF via 65535 grants (or force) plus one more grant → trigger_count=0x0000.
